// File: rtl/phase_arbiter_if.sv
// Strobe, request and grant bundle between the clock unit, the approx-adder requesters and phase_arbiter.
interface phase_arbiter_if;
  logic       phi1_i;
  logic       phi2_i;
  logic       hold_i;
  logic [3:0] req_i;
  logic [3:0] done_i;
  logic [3:0] max_slots_i;
  logic [3:0] gnt_o;
  logic [1:0] owner_o;
  logic       busy_o;
  logic       timeout_o;

  modport master (
    output phi1_i, phi2_i, hold_i, req_i, done_i, max_slots_i,
    input  gnt_o, owner_o, busy_o, timeout_o
  );

  modport slave (
    input  phi1_i, phi2_i, hold_i, req_i, done_i, max_slots_i,
    output gnt_o, owner_o, busy_o, timeout_o
  );
endinterface

// File: rtl/phase_arbiter.sv
// Round-robin arbiter for 4 requesters: grant on the phi1 edge, burst limited in phi2 slots, 1-cycle guard after release.
// Outputs registered (1 edge after the sampled strobe); hold_i freezes everything and drops strobes.
module phase_arbiter (
  input  logic            clk_i,
  input  logic            clear_i,
  phase_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, OWN, GUARD} state_t;

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic       busy_q, busy_d;
  logic       tmo_q, tmo_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] lim_q, lim_d;
  logic [4:0] cnt_inc;
  logic [1:0] cand;
  logic [1:0] winner;
  logic       win_vld;

  // Lowest offset from last_q+1 wins, so iterate from the far end down.
  always_comb begin
    cand    = 2'd0;
    winner  = 2'd0;
    win_vld = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      cand = last_q + 2'(i) + 2'd1;
      if (bus.req_i[cand]) begin
        win_vld = 1'b1;
        winner  = cand;
      end
    end
  end

  assign cnt_inc = cnt_q + 5'd1;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    tmo_d   = 1'b0;
    if (!bus.hold_i) begin
      case (state_q)
        IDLE: begin
          if (bus.phi1_i && win_vld) begin
            state_d = OWN;
            gnt_d   = 4'b0001 << winner;
            owner_d = winner;
            busy_d  = 1'b1;
            cnt_d   = 5'd0;
            lim_d   = (bus.max_slots_i == 4'd0) ? 5'd16 : {1'b0, bus.max_slots_i};
          end
        end
        OWN: begin
          // Voluntary release takes precedence over a coincident limit hit.
          if (bus.done_i[owner_q] || !bus.req_i[owner_q]) begin
            state_d = GUARD;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
            last_d  = owner_q;
          end else if (bus.phi2_i && (cnt_inc == lim_q)) begin
            state_d = GUARD;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
            last_d  = owner_q;
            tmo_d   = 1'b1;
          end else if (bus.phi2_i) begin
            cnt_d = cnt_inc;
          end
        end
        GUARD: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!clear_i) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      owner_q <= 2'd0;
      last_q  <= 2'd3;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= 5'd0;
      lim_q   <= 5'd16;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.owner_o   = owner_q;
  assign bus.busy_o    = busy_q;
  assign bus.timeout_o = tmo_q & ~bus.hold_i;

endmodule

// File: tb/tb_phase_arbiter.sv
// Scenario bench for phase_arbiter: expected outputs queued per driven cycle, compared after the edge.
module tb_phase_arbiter;

  logic clk_i = 1'b0;
  logic clear_i;
  int   checks = 0;
  int   errors = 0;

  phase_arbiter_if bus ();

  phase_arbiter dut (
    .clk_i   (clk_i),
    .clear_i (clear_i),
    .bus     (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       tmo;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Queue the expected post-edge outputs, advance one edge, then pop and compare.
  task automatic tick(input string tag, input logic [3:0] g, input logic [1:0] o,
                      input logic b, input logic t);
    exp_t e;
    e.tag = tag; e.gnt = g; e.owner = o; e.busy = b; e.tmo = t;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    check({e.tag, ".gnt"},   {4'd0, bus.gnt_o},     {4'd0, e.gnt});
    check({e.tag, ".owner"}, {6'd0, bus.owner_o},   {6'd0, e.owner});
    check({e.tag, ".busy"},  {7'd0, bus.busy_o},    {7'd0, e.busy});
    check({e.tag, ".tmo"},   {7'd0, bus.timeout_o}, {7'd0, e.tmo});
  endtask

  initial begin
    clear_i = 1'b0;
    bus.phi1_i = 1'b0; bus.phi2_i = 1'b0; bus.hold_i = 1'b0;
    bus.req_i = 4'b0000; bus.done_i = 4'b0000; bus.max_slots_i = 4'd0;
    #1;
    tick("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    clear_i = 1'b1;

    // No phi1: requests alone do not grant
    bus.req_i = 4'b1010;
    tick("idle_nophi1", 4'b0000, 2'd0, 1'b0, 1'b0);

    // First grant after reset goes to lowest requester above 3 wrapping
    bus.phi1_i = 1'b1; bus.max_slots_i = 4'd3;
    tick("grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
    bus.phi1_i = 1'b0; bus.max_slots_i = 4'd0;   // limit already latched at 3
    bus.done_i = 4'b0101;                        // non-owner releases ignored
    for (int p = 1; p <= 2; p++) begin
      bus.phi2_i = 1'b1; tick($sformatf("burst1_p%0d", p), 4'b0010, 2'd1, 1'b1, 1'b0);
      bus.phi2_i = 1'b0; tick($sformatf("burst1_g%0d", p), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    bus.phi2_i = 1'b1; tick("limit3", 4'b0000, 2'd1, 1'b0, 1'b1);
    bus.phi2_i = 1'b0; bus.done_i = 4'b0000;
    tick("after_guard1", 4'b0000, 2'd1, 1'b0, 1'b0);
    bus.phi1_i = 1'b1;
    tick("rr_next3", 4'b1000, 2'd3, 1'b1, 1'b0);

    // Reset mid-burst of owner 3
    bus.phi1_i = 1'b0; bus.phi2_i = 1'b1;
    tick("own3_p1", 4'b1000, 2'd3, 1'b1, 1'b0);
    bus.phi2_i = 1'b0; clear_i = 1'b0;
    tick("clear_mid", 4'b0000, 2'd0, 1'b0, 1'b0);
    clear_i = 1'b1; bus.req_i = 4'b1111; bus.phi1_i = 1'b1; bus.max_slots_i = 4'd5;
    tick("post_clear", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Owner 0, limit 5: two slots, hold with phi2 activity, then three more slots
    bus.phi1_i = 1'b0;
    for (int p = 1; p <= 2; p++) begin
      bus.phi2_i = 1'b1; tick($sformatf("pre_hold_p%0d", p), 4'b0001, 2'd0, 1'b1, 1'b0);
      bus.phi2_i = 1'b0; tick($sformatf("pre_hold_g%0d", p), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    bus.hold_i = 1'b1; bus.phi2_i = 1'b1;
    for (int h = 0; h < 5; h++) tick($sformatf("hold%0d", h), 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.hold_i = 1'b0; bus.phi2_i = 1'b0;
    tick("unhold", 4'b0001, 2'd0, 1'b1, 1'b0);
    for (int p = 3; p <= 4; p++) begin
      bus.phi2_i = 1'b1; tick($sformatf("post_hold_p%0d", p), 4'b0001, 2'd0, 1'b1, 1'b0);
      bus.phi2_i = 1'b0; tick($sformatf("post_hold_g%0d", p), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
    bus.phi2_i = 1'b1; tick("limit5", 4'b0000, 2'd0, 1'b0, 1'b1);
    bus.phi2_i = 1'b0;
    tick("guard_to_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Owner 2, limit 16, done coincides with 16th slot
    bus.req_i = 4'b0100; bus.max_slots_i = 4'd0; bus.phi1_i = 1'b1;
    tick("grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
    bus.phi1_i = 1'b0;
    for (int p = 1; p <= 15; p++) begin
      bus.phi2_i = 1'b1; tick($sformatf("own2_p%0d", p), 4'b0100, 2'd2, 1'b1, 1'b0);
      bus.phi2_i = 1'b0; tick($sformatf("own2_g%0d", p), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    bus.phi2_i = 1'b1; bus.done_i = 4'b0100;
    tick("done_at16", 4'b0000, 2'd2, 1'b0, 1'b0);
    bus.phi2_i = 1'b0; bus.done_i = 4'b0000;
    tick("idle_after16", 4'b0000, 2'd2, 1'b0, 1'b0);

    // phi1 during guard must not grant
    bus.req_i = 4'b0001; bus.phi1_i = 1'b1;
    tick("grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    bus.req_i = 4'b0000; bus.phi1_i = 1'b0;
    tick("req_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.req_i = 4'b0001; bus.phi1_i = 1'b1;
    tick("phi1_in_guard", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.phi1_i = 1'b0;
    tick("no_queue", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.phi1_i = 1'b1;
    tick("regrant0", 4'b0001, 2'd0, 1'b1, 1'b0);

    // phi1 during hold is lost
    bus.req_i = 4'b0000; bus.phi1_i = 1'b0;
    tick("rel0", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick("idle0", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.req_i = 4'b0010; bus.phi1_i = 1'b1; bus.hold_i = 1'b1;
    tick("hold_phi1", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.hold_i = 1'b0; bus.phi1_i = 1'b0;
    tick("phi1_lost", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.phi1_i = 1'b1;
    tick("grant1b", 4'b0010, 2'd1, 1'b1, 1'b0);

    // Reset beats hold, and restores requester 0 priority
    bus.phi1_i = 1'b0; bus.hold_i = 1'b1; clear_i = 1'b0;
    tick("clear_vs_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
    bus.hold_i = 1'b0; clear_i = 1'b1; bus.req_i = 4'b1111; bus.phi1_i = 1'b1;
    tick("prio0", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_arbiter.md
PHASE_ARBITER -- requirements
Module: phase_arbiter

Interface
REQ-001 SHALL provide clk_i  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL provide clear_i  input  1  reset, synchronous, active-low.
REQ-003 SHALL provide phi1_i  input  1  phase-1 strobe from the clock unit; arbitration point.
REQ-004 SHALL provide phi2_i  input  1  phase-2 strobe; slot-count point.
REQ-005 SHALL provide hold_i  input  1  freeze; all state and outputs held while high.
REQ-006 SHALL provide req_i  input  4  per-requester access request (approx-adder units 0..3).
REQ-007 SHALL provide done_i  input  4  per-requester voluntary release.
REQ-008 SHALL provide max_slots_i  input  4  burst limit in phi2 slots; 0 means 16.
REQ-009 SHALL provide gnt_o  output  4  one-hot grant, registered.
REQ-010 SHALL provide owner_o  output  2  index of current/last owner, registered.
REQ-011 SHALL provide busy_o  output  1  high while any grant is held.
REQ-012 SHALL provide timeout_o  output  1  one-cycle pulse on forced release at burst limit.

Function
REQ-013 SHALL implement states IDLE, OWN, GUARD.
REQ-014 IDLE: SHALL sample req_i only in a cycle with phi1_i=1; if nonzero, SHALL pick the winner by round-robin, starting at (last_owner+1) mod 4 and searching upward with wrap.
REQ-015 SHALL assert gnt_o one-hot and busy_o=1, update owner_o, clear slot counter, and enter OWN on the clock edge that samples phi1_i=1.
REQ-016 IDLE with phi1_i=0 or req_i=0: SHALL stay IDLE, gnt_o=0.
REQ-017 OWN: SHALL increment the 5-bit slot counter on each cycle with phi2_i=1.
REQ-018 OWN: SHALL release when done_i[owner]=1, req_i[owner]=0, or the counter reaches the limit (max_slots_i, 0 = 16).
REQ-019 On release: SHALL drive gnt_o=0 and busy_o=0 on the next edge and enter GUARD; last_owner SHALL be the released owner.
REQ-020 Limit reached in the same cycle as done_i[owner] or req_i[owner]=0: SHALL treat as voluntary release; timeout_o stays 0.
REQ-021 Limit-only release: SHALL pulse timeout_o for exactly one cycle, coincident with the GUARD entry edge.
REQ-022 GUARD: SHALL last exactly one cycle with gnt_o=0, then enter IDLE; a phi1_i in GUARD SHALL NOT grant.
REQ-023 done_i/req_i bits of non-owners SHALL be ignored in OWN.
REQ-024 max_slots_i SHALL be sampled at grant and held for the whole burst.
REQ-025 hold_i=1: SHALL freeze state, counter, pointer and outputs, except timeout_o, which SHALL be 0; phi strobes during hold SHALL be lost, not queued.
REQ-026 hold_i and clear_i=0 together: reset SHALL win.
REQ-027 gnt_o SHALL never have more than one bit set, and SHALL never be nonzero outside OWN.

Reset
REQ-028 clear_i=0 at a clock edge SHALL force IDLE, gnt_o=0, owner_o=0, busy_o=0, timeout_o=0, counter=0, last_owner=3, so requester 0 has first priority.
REQ-029 Reset asserted mid-burst SHALL drop the grant on that edge with no GUARD cycle and no timeout pulse.

Verification
REQ-030 Reset, then req_i=4'b1010, phi1 pulse -> gnt_o=4'b0010, owner_o=1 on that edge; busy_o=1.
REQ-031 Owner 1, max_slots_i=3, req held, no done, 3 phi2 pulses -> gnt_o=0 on the edge after the 3rd pulse; timeout_o=1 for one cycle; next phi1 with req_i=4'b1010 -> gnt_o=4'b1000.
REQ-032 Owner 2, done_i[2] and 16th phi2 coincide with max_slots_i=0 -> release with timeout_o=0.
REQ-033 Owner 0, hold_i=1 for 5 cycles with phi2 pulses -> counter and gnt_o unchanged; after hold drops, counting resumes from the prior value.
REQ-034 Owner 3 mid-burst, clear_i=0 one cycle -> gnt_o=0 same edge; then req_i=4'b1111 with phi1 -> gnt_o=4'b0001.
REQ-035 Release followed by phi1 in the GUARD cycle with req_i=4'b0001 -> no grant until the next phi1 after GUARD.
